// File: rtl/mbus_rx_msg_buffer_pkg.sv
// Shared widths, FIFO entry encoding and FSM state type for the MBus receive message buffer.
package mbus_rx_msg_buffer_pkg;

    localparam int unsigned ADDR_WIDTH  = 8;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned TYPE_WIDTH  = 2;
    localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + TYPE_WIDTH;
    localparam int unsigned CNT_WIDTH   = 8;

    typedef enum logic [TYPE_WIDTH-1:0] {
        TYPE_HDR      = 2'b00,
        TYPE_DATA     = 2'b01,
        TYPE_END_OK   = 2'b10,
        TYPE_END_FAIL = 2'b11
    } entry_type_e;

    typedef struct packed {
        entry_type_e             etype;
        logic [DATA_WIDTH-1:0]   data;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_HDR     = 3'd1,
        ST_W_DATA    = 3'd2,
        ST_W_END     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_NEXT = 3'd5
    } state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mbus_rx_msg_buffer_if.sv
// Node-side receive handshake plus consumer-side FIFO read port of the message buffer.
interface mbus_rx_msg_buffer_if;
    import mbus_rx_msg_buffer_pkg::*;

    logic [ADDR_WIDTH-1:0] RX_ADDR;
    logic [DATA_WIDTH-1:0] RX_DATA;
    logic                  RX_REQ;
    logic                  RX_PEND;
    logic                  RX_BROADCAST;
    logic                  RX_FAIL;
    logic                  RX_ACK;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic [TYPE_WIDTH-1:0] OUT_TYPE;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [CNT_WIDTH-1:0]  OVF_CNT;

    modport slave (
        input  RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_BROADCAST, RX_FAIL, OUT_READY,
        output RX_ACK, OUT_DATA, OUT_TYPE, OUT_VALID, OVF_CNT
    );

    modport master (
        output RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_BROADCAST, RX_FAIL, OUT_READY,
        input  RX_ACK, OUT_DATA, OUT_TYPE, OUT_VALID, OVF_CNT
    );

endinterface

// File: rtl/mbus_rx_msg_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; occupancy counter drives full/empty.
module mbus_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Head is forced to zero while empty so idle outputs read as zero.
    assign rdata = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop_ok);
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/mbus_rx_msg_buffer.sv
// Frames node receive words into HDR/DATA/END entries and queues them in a FWFT FIFO.
module mbus_rx_msg_buffer
    import mbus_rx_msg_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,   // power of two, >= 4
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   CLK_EXT,
    input  logic                   RESETn,
    mbus_rx_msg_buffer_if.slave    bus
);

    logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
    logic [SYNC_STAGES-1:0] fail_sync_q, fail_sync_d;
    logic                   rreq, rfail;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0]   ovf_q, ovf_d;
    logic                   rx_ack_q, rx_ack_d;
    logic                   pend_q, pend_d;
    logic                   fail_pend_q, fail_pend_d;

    logic                   fail_now, write_state;
    logic                   push;
    entry_t                 push_entry, head;
    logic [ENTRY_WIDTH-1:0] fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count_unused;

    assign rreq  = req_sync_q[SYNC_STAGES-1];
    assign rfail = fail_sync_q[SYNC_STAGES-1];

    always_comb begin
        req_sync_d  = (req_sync_q << 1) | SYNC_STAGES'(bus.RX_REQ);
        fail_sync_d = (fail_sync_q << 1) | SYNC_STAGES'(bus.RX_FAIL);
    end

    // A failure seen while the FIFO is full is remembered until END_FAIL fits.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ovf_d       = ovf_q;
        rx_ack_d    = 1'b0;
        pend_d      = pend_q;
        fail_pend_d = fail_pend_q;
        push        = 1'b0;
        push_entry  = '0;

        fail_now    = fail_pend_q || rfail;
        write_state = (state_q == ST_W_HDR) || (state_q == ST_W_DATA) || (state_q == ST_W_END) ||
                      ((state_q == ST_WAIT_NEXT) && fail_now);
        if (write_state && fifo_full) ovf_d = sat_inc(ovf_q);

        unique case (state_q)
            ST_IDLE: begin
                fail_pend_d = 1'b0;
                if (rreq) begin
                    state_d = ST_W_HDR;
                    wcnt_d  = '0;
                end
            end
            ST_ACK: begin
                if (rreq) rx_ack_d = 1'b1;
                else      state_d  = pend_q ? ST_WAIT_NEXT : ST_IDLE;
            end
            default: begin
                if (fail_now) begin
                    if (fifo_full) begin
                        fail_pend_d = 1'b1;
                    end else begin
                        push             = 1'b1;
                        push_entry.etype = TYPE_END_FAIL;
                        push_entry.data  = DATA_WIDTH'(wcnt_q);
                        fail_pend_d      = 1'b0;
                        state_d          = ST_IDLE;
                    end
                end else if (state_q == ST_WAIT_NEXT) begin
                    if (rreq) state_d = ST_W_DATA;
                end else if (!fifo_full) begin
                    push = 1'b1;
                    if (state_q == ST_W_HDR) begin
                        push_entry.etype = TYPE_HDR;
                        push_entry.data  = DATA_WIDTH'({bus.RX_BROADCAST, bus.RX_ADDR});
                        state_d          = ST_W_DATA;
                    end else if (state_q == ST_W_DATA) begin
                        push_entry.etype = TYPE_DATA;
                        push_entry.data  = bus.RX_DATA;
                        wcnt_d           = sat_inc(wcnt_q);
                        pend_d           = bus.RX_PEND;
                        state_d          = bus.RX_PEND ? ST_ACK : ST_W_END;
                        rx_ack_d         = bus.RX_PEND;
                    end else begin
                        push_entry.etype = TYPE_END_OK;
                        push_entry.data  = DATA_WIDTH'(wcnt_q);
                        state_d          = ST_ACK;
                        rx_ack_d         = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK_EXT) begin
        if (!RESETn) begin
            req_sync_q  <= '0;
            fail_sync_q <= '0;
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            ovf_q       <= '0;
            rx_ack_q    <= 1'b0;
            pend_q      <= 1'b0;
            fail_pend_q <= 1'b0;
        end else begin
            req_sync_q  <= req_sync_d;
            fail_sync_q <= fail_sync_d;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ovf_q       <= ovf_d;
            rx_ack_q    <= rx_ack_d;
            pend_q      <= pend_d;
            fail_pend_q <= fail_pend_d;
        end
    end

    mbus_sync_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK_EXT),
        .rst_n (RESETn),
        .push  (push),
        .wdata (push_entry),
        .pop   (bus.OUT_READY),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    assign head          = entry_t'(fifo_rdata);
    assign bus.OUT_DATA  = head.data;
    assign bus.OUT_TYPE  = head.etype;
    assign bus.OUT_VALID = !fifo_empty;
    assign bus.RX_ACK    = rx_ack_q;
    assign bus.OVF_CNT   = ovf_q;

endmodule
